// File: rtl/control.sv
// control: memory-interface control unit for the 16-bit teaching CPU.
// Purpose: steers abus, memory strobes and the dbus/data tri-state buses for
//   instruction fetch, byte data read and byte data write, and holds the
//   fetched instruction in the irnew register.
// Latency: strobes, address and bus steering are combinational; irnew loads
//   on the t1 edge after the fetch word is on dbus.
// Backpressure: none; the core holds its request for as long as memory needs.
// Optional feature: define IRNEW_BYPASS_EN to show dbus on irnew
//   combinationally during a fetch, ahead of the register load.
module control (
  input  logic        t1,
  input  logic        rst,
  input  logic        irr,
  input  logic [15:0] pc,
  output logic [15:0] irnew,
  input  logic [15:0] aluout,
  inout  wire  [7:0]  data,
  input  logic        nDRD,
  input  logic        nDWR,
  output logic [15:0] abus,
  inout  wire  [15:0] dbus,
  output logic        nmreq,
  output logic        nrd,
  output logic        nwr,
  output logic        nbhe,
  output logic        nble
);

  // One access mode at a time; fetch outranks data read, which outranks write.
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FETCH = 2'd1,
    MODE_DRD   = 2'd2,
    MODE_DWR   = 2'd3
  } mode_e;

  mode_e       mode;
  logic [15:0] irnew_q;
  logic [15:0] irnew_d;
  logic        dbus_oe;
  logic        data_oe;
  logic [7:0]  rd_byte;

  // Decode the active access from the request lines; reset forces idle so
  // strobes drop and both buses release immediately.
  always_comb begin
    mode = MODE_IDLE;
    if (rst) begin
      mode = MODE_IDLE;
    end else if (irr) begin
      mode = MODE_FETCH;
    end else if (!nDRD) begin
      mode = MODE_DRD;
    end else if (!nDWR) begin
      mode = MODE_DWR;
    end
  end

  // Drive address, strobes, lane enables and bus output enables per mode.
  // Data accesses use aluout[0] to pick the byte lane: even -> low, odd -> high.
  always_comb begin
    abus    = 16'h0000;
    nmreq   = 1'b1;
    nrd     = 1'b1;
    nwr     = 1'b1;
    nbhe    = 1'b1;
    nble    = 1'b1;
    dbus_oe = 1'b0;
    data_oe = 1'b0;
    unique case (mode)
      MODE_FETCH: begin
        abus  = pc;
        nmreq = 1'b0;
        nrd   = 1'b0;
        nbhe  = 1'b0;
        nble  = 1'b0;
      end
      MODE_DRD: begin
        abus    = aluout;
        nmreq   = 1'b0;
        nrd     = 1'b0;
        nbhe    = ~aluout[0];
        nble    = aluout[0];
        data_oe = 1'b1;
      end
      MODE_DWR: begin
        abus    = aluout;
        nmreq   = 1'b0;
        nwr     = 1'b0;
        nbhe    = ~aluout[0];
        nble    = aluout[0];
        dbus_oe = 1'b1;
      end
      default: begin
        abus = 16'h0000;
      end
    endcase
  end

  // Select the addressed byte lane of the memory word for a data read.
  always_comb begin
    rd_byte = aluout[0] ? dbus[15:8] : dbus[7:0];
  end

  // The block only drives dbus on a write (nrd high) and data on a read
  // (nwr high), so neither bus is ever driven against the other side.
  assign dbus = dbus_oe ? {data, data} : 16'hzzzz;
  assign data = data_oe ? rd_byte : 8'hzz;

  // Next instruction word: capture dbus whenever a fetch is requested.
  always_comb begin
    irnew_d = irnew_q;
    if (irr) begin
      irnew_d = dbus;
    end
  end

  // Instruction register, cleared asynchronously on reset.
  always_ff @(posedge t1 or posedge rst) begin
    if (rst) begin
      irnew_q <= 16'h0000;
    end else begin
      irnew_q <= irnew_d;
    end
  end

`ifdef IRNEW_BYPASS_EN
  // Expose the word on dbus during a fetch so decode can start before the edge.
  assign irnew = (!rst && irr) ? dbus : irnew_q;
`else
  assign irnew = irnew_q;
`endif

endmodule

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for the control memory interface.
// Tristate outputs are probed by driving the far side of each bus with a known
// pattern and checking the net still reads that pattern (no second driver).
`timescale 1ns/100ps
module tb_control;

  logic        t1;
  logic        rst;
  logic        irr;
  logic [15:0] pc;
  logic [15:0] aluout;
  logic        nDRD;
  logic        nDWR;
  wire  [15:0] irnew;
  wire  [15:0] abus;
  wire         nmreq;
  wire         nrd;
  wire         nwr;
  wire         nbhe;
  wire         nble;
  wire  [7:0]  data;
  wire  [15:0] dbus;

  // Memory side and core side bus drivers.
  logic        mem_en;
  logic [15:0] mem_val;
  logic        core_en;
  logic [7:0]  core_val;

  assign dbus = mem_en  ? mem_val  : 16'hzzzz;
  assign data = core_en ? core_val : 8'hzz;

  wire [4:0] strb = {nmreq, nrd, nwr, nbhe, nble};

  int n_cmp;
  int n_bad;

  control dut (
    .t1     (t1),
    .rst    (rst),
    .irr    (irr),
    .pc     (pc),
    .irnew  (irnew),
    .aluout (aluout),
    .data   (data),
    .nDRD   (nDRD),
    .nDWR   (nDWR),
    .abus   (abus),
    .dbus   (dbus),
    .nmreq  (nmreq),
    .nrd    (nrd),
    .nwr    (nwr),
    .nbhe   (nbhe),
    .nble   (nble)
  );

  initial t1 = 1'b0;
  always #5 t1 = ~t1;

  task automatic test_reset;
    rst = 1'b1; irr = 1'b0; nDRD = 1'b1; nDWR = 1'b1;
    pc = 16'h1357; aluout = 16'h2468;
    mem_en = 1'b1; mem_val = 16'hA5C3;
    core_en = 1'b1; core_val = 8'h3C;
    #1;
    n_cmp++; if (irnew !== 16'h0000) begin n_bad++; $display("FAIL reset_irnew got %h want 0000", irnew); end
    n_cmp++; if (strb !== 5'b11111) begin n_bad++; $display("FAIL reset_strobes got %b want 11111", strb); end
    n_cmp++; if (abus !== 16'h0000) begin n_bad++; $display("FAIL reset_abus got %h want 0000", abus); end
    n_cmp++; if (dbus !== 16'hA5C3) begin n_bad++; $display("FAIL reset_dbus_z got %h want A5C3", dbus); end
    n_cmp++; if (data !== 8'h3C) begin n_bad++; $display("FAIL reset_data_z got %h want 3C", data); end
    rst = 1'b0;
    #1;
    n_cmp++; if (strb !== 5'b11111) begin n_bad++; $display("FAIL idle_strobes got %b want 11111", strb); end
    n_cmp++; if (abus !== 16'h0000) begin n_bad++; $display("FAIL idle_abus got %h want 0000", abus); end
  endtask

  task automatic test_fetch;
    logic [15:0] pre_exp;
    @(negedge t1);
    irr = 1'b1; pc = 16'h0000;
    mem_en = 1'b1; mem_val = 16'h2399;
    core_en = 1'b1; core_val = 8'h5A;
`ifdef IRNEW_BYPASS_EN
    pre_exp = 16'h2399;
`else
    pre_exp = 16'h0000;
`endif
    #1;
    n_cmp++; if (strb !== 5'b00100) begin n_bad++; $display("FAIL fetch_strobes got %b want 00100", strb); end
    n_cmp++; if (abus !== 16'h0000) begin n_bad++; $display("FAIL fetch_abus got %h want 0000", abus); end
    n_cmp++; if (data !== 8'h5A) begin n_bad++; $display("FAIL fetch_data_z got %h want 5A", data); end
    n_cmp++; if (irnew !== pre_exp) begin n_bad++; $display("FAIL fetch_pre_edge got %h want %h", irnew, pre_exp); end
    @(posedge t1); #1;
    n_cmp++; if (irnew !== 16'h2399) begin n_bad++; $display("FAIL fetch_load got %h want 2399", irnew); end
    // Drop the request; the register must hold across a further edge.
    @(negedge t1);
    irr = 1'b0; mem_val = 16'h7777;
    @(posedge t1); #1;
    n_cmp++; if (irnew !== 16'h2399) begin n_bad++; $display("FAIL fetch_hold got %h want 2399", irnew); end
  endtask

  task automatic test_data_read;
    @(negedge t1);
    nDRD = 1'b0; aluout = 16'h0021;
    mem_en = 1'b1; mem_val = 16'h2399;
    core_en = 1'b0;
    #1;
    n_cmp++; if (abus !== 16'h0021) begin n_bad++; $display("FAIL rd_odd_abus got %h want 0021", abus); end
    n_cmp++; if (strb !== 5'b00101) begin n_bad++; $display("FAIL rd_odd_strobes got %b want 00101", strb); end
    n_cmp++; if (data !== 8'h23) begin n_bad++; $display("FAIL rd_odd_data got %h want 23", data); end
    aluout = 16'h0020;
    #1;
    n_cmp++; if (strb !== 5'b00110) begin n_bad++; $display("FAIL rd_even_strobes got %b want 00110", strb); end
    n_cmp++; if (data !== 8'h99) begin n_bad++; $display("FAIL rd_even_data got %h want 99", data); end
    n_cmp++; if (dbus !== 16'h2399) begin n_bad++; $display("FAIL rd_dbus_z got %h want 2399", dbus); end
    @(posedge t1); #1;
    n_cmp++; if (irnew !== 16'h2399) begin n_bad++; $display("FAIL rd_irnew_hold got %h want 2399", irnew); end
  endtask

  task automatic test_data_write;
    @(negedge t1);
    nDRD = 1'b1; nDWR = 1'b0; aluout = 16'h0021;
    mem_en = 1'b0;
    core_en = 1'b1; core_val = 8'hE3;
    #1;
    n_cmp++; if (strb !== 5'b01001) begin n_bad++; $display("FAIL wr_odd_strobes got %b want 01001", strb); end
    n_cmp++; if (dbus !== 16'hE3E3) begin n_bad++; $display("FAIL wr_dbus got %h want E3E3", dbus); end
    n_cmp++; if (abus !== 16'h0021) begin n_bad++; $display("FAIL wr_abus got %h want 0021", abus); end
    aluout = 16'hFFFE;
    #1;
    n_cmp++; if (strb !== 5'b01010) begin n_bad++; $display("FAIL wr_even_strobes got %b want 01010", strb); end
    n_cmp++; if (abus !== 16'hFFFE) begin n_bad++; $display("FAIL wr_even_abus got %h want FFFE", abus); end
    nDWR = 1'b1;
    mem_en = 1'b1; mem_val = 16'h1234;
    #1;
    n_cmp++; if (dbus !== 16'h1234) begin n_bad++; $display("FAIL wr_end_dbus_z got %h want 1234", dbus); end
    n_cmp++; if (strb !== 5'b11111) begin n_bad++; $display("FAIL wr_end_strobes got %b want 11111", strb); end
  endtask

  task automatic test_priority;
    @(negedge t1);
    irr = 1'b1; nDRD = 1'b0; nDWR = 1'b1;
    pc = 16'h1111; aluout = 16'h0021;
    mem_en = 1'b1; mem_val = 16'hABCD;
    core_en = 1'b1; core_val = 8'h5A;
    #1;
    n_cmp++; if (abus !== 16'h1111) begin n_bad++; $display("FAIL prio_abus got %h want 1111", abus); end
    n_cmp++; if (strb !== 5'b00100) begin n_bad++; $display("FAIL prio_strobes got %b want 00100", strb); end
    n_cmp++; if (data !== 8'h5A) begin n_bad++; $display("FAIL prio_data_z got %h want 5A", data); end
    // Read and write together: read wins.
    irr = 1'b0; nDWR = 1'b0; core_en = 1'b0;
    #1;
    n_cmp++; if (strb !== 5'b00101) begin n_bad++; $display("FAIL rdwr_strobes got %b want 00101", strb); end
    n_cmp++; if (data !== 8'hAB) begin n_bad++; $display("FAIL rdwr_data got %h want AB", data); end
    n_cmp++; if (dbus !== 16'hABCD) begin n_bad++; $display("FAIL rdwr_dbus_z got %h want ABCD", dbus); end
    nDRD = 1'b1; nDWR = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] pre_exp;
    @(negedge t1);
    irr = 1'b1; pc = 16'h0042;
    mem_en = 1'b1; mem_val = 16'h2399;
    core_en = 1'b1; core_val = 8'h5A;
    @(posedge t1); #1;
    n_cmp++; if (irnew !== 16'h2399) begin n_bad++; $display("FAIL mid_preload got %h want 2399", irnew); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (irnew !== 16'h0000) begin n_bad++; $display("FAIL mid_irnew got %h want 0000", irnew); end
    n_cmp++; if (strb !== 5'b11111) begin n_bad++; $display("FAIL mid_strobes got %b want 11111", strb); end
    n_cmp++; if (abus !== 16'h0000) begin n_bad++; $display("FAIL mid_abus got %h want 0000", abus); end
    n_cmp++; if (data !== 8'h5A) begin n_bad++; $display("FAIL mid_data_z got %h want 5A", data); end
    // Release with the fetch still requested.
    rst = 1'b0; mem_val = 16'hBEEF;
`ifdef IRNEW_BYPASS_EN
    pre_exp = 16'hBEEF;
`else
    pre_exp = 16'h0000;
`endif
    #0.5;
    n_cmp++; if (strb !== 5'b00100) begin n_bad++; $display("FAIL rel_strobes got %b want 00100", strb); end
    n_cmp++; if (abus !== 16'h0042) begin n_bad++; $display("FAIL rel_abus got %h want 0042", abus); end
    n_cmp++; if (irnew !== pre_exp) begin n_bad++; $display("FAIL rel_pre_edge got %h want %h", irnew, pre_exp); end
    @(posedge t1); #1;
    n_cmp++; if (irnew !== 16'hBEEF) begin n_bad++; $display("FAIL rel_load got %h want BEEF", irnew); end
    @(negedge t1);
    irr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_fetch();
    test_data_read();
    test_data_write();
    test_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
